// File: rtl/prog_loader_if.sv
// Loader bus: byte stream in, instruction-memory write port and status out.
// Pure wiring, no latency.
// rx_valid/rx_ready handshake; a byte moves on a rising edge with both high.
interface prog_loader_if #(
    parameter int ADDR_W = 8
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_wdata;
    logic              cpu_hold;
    logic              load_done;
    logic              load_error;
    logic [ADDR_W-1:0] word_count;

    // master: the loader itself
    modport master (
        input  rx_valid, rx_data,
        output rx_ready, imem_we, imem_addr, imem_wdata,
               cpu_hold, load_done, load_error, word_count
    );

    // slave: byte source plus memory/CPU side
    modport slave (
        output rx_valid, rx_data,
        input  rx_ready, imem_we, imem_addr, imem_wdata,
               cpu_hold, load_done, load_error, word_count
    );
endinterface

// File: rtl/prog_loader.sv
// Boot loader: parses HEADER/LEN/data/CSUM frames into instruction memory, holds CPU until done.
// Latency: imem_we one cycle after the LO byte; load_done one cycle after the CSUM byte.
// Backpressure: rx_ready drops during the WRITE cycle and permanently once DONE.
module prog_loader #(
    parameter int         ADDR_W = 8,
    parameter logic [7:0] HEADER = 8'hA5
) (
    input  logic          clk,
    input  logic          reset,
    prog_loader_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_HI, S_LO, S_WRITE, S_CSUM, S_DONE, S_ERR
    } state_t;

    state_t            state;
    logic              rx_ready_q;
    logic              imem_we_q;
    logic [ADDR_W-1:0] imem_addr_q;
    logic [15:0]       wdata_q;
    logic              cpu_hold_q;
    logic              load_done_q;
    logic              load_error_q;
    logic [ADDR_W-1:0] word_count_q;
    logic [ADDR_W-1:0] len_q;
    logic [7:0]        acc_q;
    logic              take;
    logic [ADDR_W-1:0] count_next;

    // a byte is consumed only when both sides agree this cycle
    assign take       = bus.rx_valid && rx_ready_q;
    assign count_next = word_count_q + ADDR_W'(1);

    // frame parser; every output is a register updated alongside the state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            rx_ready_q   <= 1'b1;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            wdata_q      <= '0;
            cpu_hold_q   <= 1'b1;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
            word_count_q <= '0;
            len_q        <= '0;
            acc_q        <= '0;
        end else begin
            // strobe is single-cycle; ready is high unless a branch below says otherwise
            imem_we_q  <= 1'b0;
            rx_ready_q <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (take && bus.rx_data == HEADER) state <= S_LEN;
                end
                S_LEN: begin
                    if (take) begin
                        if (bus.rx_data == 8'd0) begin
                            load_error_q <= 1'b1;
                            state        <= S_ERR;
                        end else begin
                            len_q        <= ADDR_W'(bus.rx_data);
                            word_count_q <= '0;
                            imem_addr_q  <= '0;
                            acc_q        <= '0;
                            state        <= S_HI;
                        end
                    end
                end
                S_HI: begin
                    if (take) begin
                        wdata_q[15:8] <= bus.rx_data;
                        acc_q         <= acc_q ^ bus.rx_data;
                        state         <= S_LO;
                    end
                end
                S_LO: begin
                    if (take) begin
                        // address and data are set up together with the strobe so they
                        // stay stable for the whole write cycle
                        wdata_q[7:0] <= bus.rx_data;
                        acc_q        <= acc_q ^ bus.rx_data;
                        imem_addr_q  <= word_count_q;
                        imem_we_q    <= 1'b1;
                        rx_ready_q   <= 1'b0;
                        state        <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    word_count_q <= count_next;
                    state        <= (count_next == len_q) ? S_CSUM : S_HI;
                end
                S_CSUM: begin
                    if (take) begin
                        if (bus.rx_data == acc_q) begin
                            load_done_q <= 1'b1;
                            cpu_hold_q  <= 1'b0;
                            rx_ready_q  <= 1'b0;
                            state       <= S_DONE;
                        end else begin
                            load_error_q <= 1'b1;
                            state        <= S_ERR;
                        end
                    end
                end
                S_DONE: begin
                    // terminal until reset; the CPU is running from the loaded image
                    rx_ready_q <= 1'b0;
                end
                S_ERR: begin
                    // memory is left as is; the next frame simply overwrites it
                    if (take && bus.rx_data == HEADER) begin
                        load_error_q <= 1'b0;
                        state        <= S_LEN;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.rx_ready   = rx_ready_q;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.cpu_hold   = cpu_hold_q;
    assign bus.load_done  = load_done_q;
    assign bus.load_error = load_error_q;
    assign bus.word_count = word_count_q;
endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader that fills the CPU's instruction memory from a byte stream. It holds the CPU in reset while loading, and releases it only after a framed, checksummed image has been written. It is the writer side of the instruction-memory port that the control unit reads during fetch. It sits between a byte source (UART receiver or test host) and the instruction-memory write port.

## Interface
- ADDR_W, 8, instruction-memory address width; maximum image is 255 words.
- HEADER, 8'hA5, frame start byte.

- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- rx_valid  in  1  byte source has a byte on rx_data.
- rx_data  in  8  incoming byte.
- rx_ready  out  1  loader accepts a byte this cycle; a byte transfers on a rising edge with rx_valid & rx_ready.
- imem_we  out  1  one-cycle write strobe to instruction memory.
- imem_addr  out  ADDR_W  word address for the write.
- imem_wdata  out  16  instruction word.
- cpu_hold  out  1  high keeps the CPU in reset (drives the CPU reset input).
- load_done  out  1  image written and checksum good; sticky until reset.
- load_error  out  1  last frame rejected; sticky until the next header.
- word_count  out  ADDR_W  number of words written in the current frame.

## Operation
- Frame format: HEADER, LEN (word count, 1..255), then 2*LEN data bytes with the high byte first, then CSUM. CSUM is the XOR of all data bytes only (not HEADER or LEN).
- FSM states: IDLE, LEN, HI, LO, WRITE, CSUM, DONE, ERR.
- IDLE: rx_ready=1. HEADER → LEN. Any other byte is discarded.
- LEN:
  - rx_ready=1.
  - LEN=0 → ERR.
  - Otherwise latch LEN, clear word_count, addr and xor accumulator, then → HI.
- HI: rx_ready=1. Latch the byte into wdata[15:8], XOR it into the accumulator, → LO.
- LO: rx_ready=1. Latch the byte into wdata[7:0], XOR it into the accumulator, → WRITE.
- WRITE:
  - rx_ready=0 and imem_we=1 for exactly one cycle, with imem_addr = word_count and imem_wdata = the assembled word.
  - word_count increments.
  - If the incremented count equals LEN → CSUM, else → HI.
- CSUM: rx_ready=1. On a byte, equal to the accumulator → DONE, else → ERR.
- DONE:
  - load_done=1, cpu_hold=0, rx_ready=0.
  - All input is ignored and the state persists until reset.
- ERR:
  - load_error=1, cpu_hold=1, rx_ready=1.
  - A HEADER byte clears load_error and goes to LEN; other bytes are discarded.
  - Partially written memory is not cleaned up; the next frame overwrites it.
- cpu_hold=1 in every state except DONE.
- Width rules:
  - word_count wraps never, because LEN ≤ 255 fits ADDR_W=8.
  - The accumulator is 8 bits.

## Timing
- Values in reset and immediately after its release:
  - state=IDLE, rx_ready=1, imem_we=0, imem_addr=0, imem_wdata=0.
  - cpu_hold=1, load_done=0, load_error=0, word_count=0.
- Reset asserted mid-frame aborts immediately, with no further write strobes. CPU memory contents are left as written.
- Minimum cost is 3 cycles per word (HI, LO, WRITE). imem_we rises the cycle after the LO byte is accepted.
- load_done and the cpu_hold deassertion occur the cycle after the CSUM byte is accepted. They are registered outputs, not combinational.
- rx_valid gaps of any length stall the FSM in its current state with no side effects.
- rx_data is sampled only when rx_valid & rx_ready. The value of rx_data is irrelevant when rx_valid=0.
- imem_addr and imem_wdata are stable for the entire imem_we cycle.

## Test plan
- Nominal load:
  - Stimulus: stream A5 02 12 34 56 78 08, back-to-back.
  - Response: writes addr0=16'h1234 and addr1=16'h5678, each with a single-cycle imem_we.
  - Response: load_done=1 and cpu_hold=0 one cycle after byte 08; word_count=2; further bytes are not accepted (rx_ready=0).
- Bad checksum:
  - Stimulus: A5 02 12 34 56 78 09.
  - Response: both words written, then load_error=1, cpu_hold=1, load_done=0.
  - Follow-up: the nominal frame clears the error and ends in load_done=1.
- Zero length and leading garbage:
  - Stimulus: 00 FF A5 00.
  - Response: the first two bytes are ignored, A5 00 → load_error=1, with no imem_we.
- Backpressure and gaps: nominal frame with rx_valid toggled randomly. Response is identical to the nominal load: same writes, same order, no duplicate strobes.
- Reset mid-load:
  - Stimulus: assert reset after A5 02 12 34 (one word written).
  - Response: all outputs return to reset values asynchronously, with no write strobe after reset.
  - Follow-up: a subsequent nominal frame completes normally.
- Max length: LEN=FF with 255 incrementing words and the correct CSUM. Last write is at addr FE, word_count=FF, load_done=1.
